// File: rtl/huffman_seq.sv
// Frame sequencer in front of a Huffman core: reads a frame of pixels from
// memory, forwards in-range pixels (1..6) to the core, then waits for the
// core to finish coding, guarded by a 256-cycle watchdog.
//
//   state | meaning
//   IDLE  | waiting for start; err/bad_cnt of last frame held
//   CLR   | one-cycle core reset before a new frame
//   FEED  | issue reads 0..len-1 and forward pixels (2-cycle latency)
//   DRAIN | wait for core code_valid, watchdog running
//   DONE  | one-cycle done pulse
module huffman_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       core_rst,
  output logic       gray_valid,
  output logic [7:0] gray_data,
  input  logic       CNT_valid,
  input  logic       code_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] bad_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] len_q;
  logic [7:0] addr_q;
  logic [7:0] fwd_cnt;
  logic [7:0] wdog;
  logic       rd_done;    // last address of the frame has been issued
  logic       rd_d;       // a read was issued last cycle, mem_data is valid now
  logic       cnt_seen;
  logic       start_acc;
  logic       feed_end;
  logic       pix_ok;

  assign pix_ok   = (mem_data >= 8'd1) && (mem_data <= 8'd6);
  assign core_rst = reset | (state == CLR);
  assign mem_addr = addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    start_acc = 1'b0;
    feed_end  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: state_nxt = (len_q != 8'd0) ? FEED : DONE;
      FEED: begin
        mem_rd = ~rd_done;
        // The last read's data was captured on the previous edge once
        // rd_done is set and no read is in flight.
        if (rd_done && !rd_d) begin
          feed_end  = 1'b1;
          state_nxt = (fwd_cnt != 8'd0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (code_valid || (wdog == 8'hFF)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame datapath: address counter, pixel filter, watchdog and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= 8'd0;
      addr_q     <= 8'd0;
      fwd_cnt    <= 8'd0;
      wdog       <= 8'd0;
      rd_done    <= 1'b0;
      rd_d       <= 1'b0;
      cnt_seen   <= 1'b0;
      err        <= 1'b0;
      bad_cnt    <= 8'd0;
      gray_valid <= 1'b0;
      gray_data  <= 8'd0;
    end else begin
      rd_d <= mem_rd;

      if (rd_d) begin
        if (pix_ok) begin
          gray_valid <= 1'b1;
          gray_data  <= mem_data;
          fwd_cnt    <= fwd_cnt + 8'd1;
        end else begin
          gray_valid <= 1'b0;
          if (bad_cnt != 8'hFF) bad_cnt <= bad_cnt + 8'd1;
        end
      end else begin
        gray_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_acc) begin
            len_q    <= len;
            err      <= 1'b0;
            bad_cnt  <= 8'd0;
            fwd_cnt  <= 8'd0;
            addr_q   <= 8'd0;
            rd_done  <= 1'b0;
            cnt_seen <= 1'b0;
          end
        end
        CLR: begin
          if (len_q == 8'd0) err <= 1'b1;
        end
        FEED: begin
          if (mem_rd) begin
            if (addr_q == len_q - 8'd1) rd_done <= 1'b1;
            else                        addr_q  <= addr_q + 8'd1;
          end
          if (feed_end) begin
            wdog <= 8'd0;
            if (fwd_cnt == 8'd0) err <= 1'b1;
          end
        end
        DRAIN: begin
          wdog <= wdog + 8'd1;
          if (CNT_valid) cnt_seen <= 1'b1;
          // code_valid takes priority over a simultaneous watchdog expiry
          if (code_valid) begin
            if (!cnt_seen) err <= 1'b1;
          end else if (wdog == 8'hFF) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_seq.sv
// Self-checking bench for huffman_seq: directed frames plus randomized
// frames, each compared cycle-by-cycle against a frame-level timing model.
module tb_huffman_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'd0;
  logic       core_rst;
  logic       gray_valid;
  logic [7:0] gray_data;
  logic       CNT_valid;
  logic       code_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] bad_cnt;

  logic [7:0] mem [256];
  logic [7:0] last_gray;
  int n_pass  = 0;
  int n_total = 0;

  huffman_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .core_rst   (core_rst),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .CNT_valid  (CNT_valid),
    .code_valid (code_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;

  // Pixel memory: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit good_pix(input logic [7:0] v);
    return (v >= 8'd1) && (v <= 8'd6);
  endfunction

  // Runs one frame starting now. Cycle r=0 is the start cycle. c_dly/k_dly
  // are CNT_valid/code_valid offsets from DRAIN entry; c_dly<0 or k_dly>255
  // means that signal never comes.
  task automatic run_frame(input int flen, input int c_dly, input int k_dly);
    int  nfwd, nbad, d0, dn, pi;
    bit  drain, exp_err, exp_gv, exp_rd;
    nfwd = 0;
    nbad = 0;
    for (int i = 0; i < flen; i++) begin
      if (good_pix(mem[i])) nfwd++;
      else                  nbad++;
    end
    d0 = flen + 4;
    drain = 1'b0;
    if (flen == 0) begin
      dn = 2;
      exp_err = 1'b1;
    end else if (nfwd == 0) begin
      dn = flen + 4;
      exp_err = 1'b1;
    end else begin
      drain = 1'b1;
      if (k_dly <= 255) begin
        dn = d0 + k_dly + 1;
        exp_err = !(c_dly >= 0 && c_dly < k_dly);
      end else begin
        dn = d0 + 256;
        exp_err = 1'b1;
      end
    end

    for (int r = 0; r <= dn + 1; r++) begin
      @(negedge clk);
      pi = r - 4;
      exp_gv = (pi >= 0) && (pi < flen) && good_pix(mem[pi]);
      if (exp_gv) last_gray = mem[pi];
      exp_rd = (flen > 0) && (r >= 2) && (r <= flen + 1);
      chk("busy", busy, (r >= 1) && (r <= dn));
      chk("done", done, r == dn);
      chk("core_rst", core_rst, r == 1);
      chk("mem_rd", mem_rd, exp_rd);
      if (exp_rd) chk("mem_addr", mem_addr, r - 2);
      chk("gray_valid", gray_valid, exp_gv);
      chk("gray_data", gray_data, last_gray);
      if (r >= dn) begin
        chk("err", err, exp_err);
        chk("bad_cnt", bad_cnt, nbad);
      end
      start      = (r == 0) ? 1'b1 : ((r <= dn) ? 1'($urandom_range(0, 1)) : 1'b0);
      len        = (r == 0) ? 8'(flen) : 8'($urandom);
      CNT_valid  = drain && (c_dly >= 0) && (r == d0 + c_dly);
      code_valid = drain && (k_dly <= 255) && (r >= d0 + k_dly) && (r <= dn);
    end
    start      = 1'b0;
    CNT_valid  = 1'b0;
    code_valid = 1'b0;
  endtask

  initial begin
    int flen, k, c;
    reset = 1'b1;
    start = 1'b0;
    len = 8'd0;
    CNT_valid = 1'b0;
    code_valid = 1'b0;
    last_gray = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bad_cnt", bad_cnt, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_gray_valid", gray_valid, 0);
    chk("rst_gray_data", gray_data, 0);
    chk("rst_core_rst", core_rst, 1);
    reset = 1'b0;

    // Case 1: all pixels valid
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd6;
    run_frame(4, 1, 6);

    // Case 2: mixed valid/invalid pixels
    mem[0] = 8'd0; mem[1] = 8'd2; mem[2] = 8'd7; mem[3] = 8'd255; mem[4] = 8'd3;
    run_frame(5, 2, 5);

    // Case 3: empty frame
    run_frame(0, 0, 1);

    // Case 4: nothing forwarded, DRAIN skipped
    mem[0] = 8'd9; mem[1] = 8'd9; mem[2] = 8'd9;
    run_frame(3, 1, 4);

    // Case 5: watchdog timeout, code_valid before CNT_valid, and
    // code_valid coinciding with watchdog terminal count
    mem[0] = 8'd4; mem[1] = 8'd5;
    run_frame(2, 3, 1000);
    run_frame(2, 5, 2);
    run_frame(2, 0, 255);

    // Case 6: reset mid-FEED at address 2
    for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
    for (int r = 0; r <= 4; r++) begin
      @(negedge clk);
      if (r == 4) begin
        chk("abort_mem_rd", mem_rd, 1);
        chk("abort_mem_addr", mem_addr, 2);
        reset = 1'b1;
        #1;
        chk("abort_core_rst", core_rst, 1);
      end
      start = 1'b1;
      len = (r == 0) ? 8'd6 : 8'd200;
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_gray = 8'd0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_bad_cnt", bad_cnt, 0);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_gray_valid", gray_valid, 0);
    chk("abort_gray_data", gray_data, 0);
    chk("abort_core_rst", core_rst, 0);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
    end
    run_frame(6, 1, 3);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      flen = $urandom_range(1, 24);
      for (int i = 0; i < flen; i++) begin
        if ($urandom_range(0, 4) == 0) mem[i] = 8'($urandom);
        else                           mem[i] = 8'($urandom_range(0, 9));
      end
      k = $urandom_range(1, 40);
      c = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, k + 2));
      run_frame(flen, c, k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/huffman_seq.md
HUFFMAN_SEQ -- requirements
Module: huffman_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  frame request; sampled only in IDLE.
REQ-005 len  input  8  pixel count of the frame, sampled with start; 0 = empty frame.
REQ-006 mem_rd  output  1  pixel memory read strobe.
REQ-007 mem_addr  output  8  pixel memory read address.
REQ-008 mem_data  input  8  pixel memory read data, valid the cycle after mem_rd.
REQ-009 core_rst  output  1  reset to the Huffman core; = reset OR (state==CLR).
REQ-010 gray_valid  output  1  pixel strobe to the core, registered.
REQ-011 gray_data  output  8  pixel value to the core, registered.
REQ-012 CNT_valid  input  1  core count-done pulse.
REQ-013 code_valid  input  1  core code-done level.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle frame-complete pulse.
REQ-016 err  output  1  error flag for the last frame, valid with done and held until the next start.
REQ-017 bad_cnt  output  8  out-of-range pixels dropped in the last frame, saturating at 255.

Function
REQ-018 FSM states: IDLE, CLR, FEED, DRAIN, DONE; reset enters IDLE.
REQ-019 IDLE: on start=1 latch len, clear err/bad_cnt/fwd_cnt/addr; next state is CLR.
REQ-020 CLR: lasts exactly one cycle with core_rst=1; next state is FEED if len!=0, else DONE with err=1.
REQ-021 FEED: assert mem_rd on consecutive cycles with mem_addr=0,1,...,len-1; no gaps.
REQ-022 Read issued in cycle t: mem_data captured at end of t+1; gray_valid/gray_data appear in cycle t+2 (latency 2).
REQ-023 Pixel forwarding: gray_valid=1 only if 1<=mem_data<=6; otherwise gray_valid=0, gray_data holds its previous value, and bad_cnt increments (saturating).
REQ-024 fwd_cnt (8-bit, internal) counts forwarded pixels.
REQ-025 FEED ends after the last read data has been processed, i.e. cycle t_last+2; then go to DRAIN if fwd_cnt!=0, else to DONE with err=1 (the core never finishes without input).
REQ-026 gray_valid SHALL be 0 in every state other than FEED, including the first DRAIN cycle, which gives the core its end-of-input gap.
REQ-027 DRAIN: an 8-bit watchdog clears on entry and increments each cycle.
REQ-028 DRAIN: CNT_valid=1 sets internal cnt_seen.
REQ-029 DRAIN: code_valid=1 goes to DONE; set err=1 if cnt_seen is still 0 at that cycle.
REQ-030 DRAIN: watchdog reaching 255 without code_valid goes to DONE with err=1.
REQ-031 If code_valid and the watchdog terminal count occur in the same cycle, code_valid wins and there is no timeout error.
REQ-032 DONE: done=1 for exactly one cycle; next state is IDLE.
REQ-033 start while busy=1 SHALL be ignored and not queued.
REQ-034 start in the same cycle as the DONE pulse SHALL be ignored; a new start is accepted from the following cycle in IDLE.
REQ-035 mem_rd SHALL never be asserted outside FEED, and mem_addr SHALL never exceed len-1.

Reset
REQ-036 On reset: state=IDLE; busy=0, done=0, err=0, bad_cnt=0, mem_rd=0, mem_addr=0, gray_valid=0, gray_data=0, core_rst=1; all internal counters and flags cleared.
REQ-037 Reset asserted mid-frame (any state) SHALL abort the frame within the same edge with no done pulse; the core is reset through core_rst.

Verification
REQ-038 Case 1: len=4, mem={1,2,3,6}, core model gives CNT_valid at +1 and code_valid at +6 -> four gray_valid pulses, data 1,2,3,6 in cycles t+2..t+5; done one cycle after code_valid; err=0, bad_cnt=0.
REQ-039 Case 2: len=5, mem={0,2,7,255,3} -> forwarded pixels 2,3 only; bad_cnt=3; err=0.
REQ-040 Case 3: len=0 -> CLR then DONE; no mem_rd; done=1, err=1.
REQ-041 Case 4: len=3, all pixels 9 -> no gray_valid; done=1, err=1, bad_cnt=3; DRAIN is never entered.
REQ-042 Case 5: core never raises code_valid -> done exactly 256 cycles after DRAIN entry, err=1; a second case with code_valid before CNT_valid -> err=1.
REQ-043 Case 6: reset asserted mid-FEED at address 2 -> next cycle idle/zeroed outputs, no done; start repeated during busy -> ignored; a following clean frame completes normally.
